// File: rtl/writeback_queue.sv
// In-order writeback tracker: holds issued {opecode, rd} entries, pairs the head with its
// execute or load result, and produces a registered register-file write plus a busy mask.
module writeback_queue #(
  parameter int unsigned LEN_OPECODE = 4,
  parameter int unsigned LEN_REGNO   = 4,
  parameter int unsigned LEN_REG     = 16,
  parameter int unsigned DEPTH       = 4,
  parameter logic [LEN_OPECODE-1:0] OPECODE_LD  = 'h8,
  parameter logic [LEN_OPECODE-1:0] OPECODE_CMP = 'h0,
  localparam int unsigned NUM_REGS = 2 ** LEN_REGNO,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   stall_o,
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_REGNO-1:0]   rd_regno,
  input  logic                   res_valid,
  input  logic [LEN_REG-1:0]     res_data,
  output logic                   res_ready,
  input  logic                   ld_valid,
  input  logic [LEN_REG-1:0]     ld_data,
  output logic                   ld_ready,
  input  logic                   stall_i,
  output logic                   wb_en,
  output logic [LEN_REGNO-1:0]   wb_regno,
  output logic [LEN_REG-1:0]     wb_data,
  output logic [NUM_REGS-1:0]    busy,
  output logic [CNT_W-1:0]       count,
  output logic                   err
);

  logic [LEN_OPECODE-1:0] op_q [DEPTH];
  logic [LEN_REGNO-1:0]   rd_q [DEPTH];
  logic [DEPTH-1:0]       vld_q;
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [CNT_W-1:0]       count_q;

  logic empty, full, push, retire, head_ld, head_cmp, err_set;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = valid_i & ~full;
  assign stall_o  = valid_i & full;
  assign head_ld  = (op_q[head_q] == OPECODE_LD);
  assign head_cmp = (op_q[head_q] == OPECODE_CMP);

  assign res_ready = ~empty & ~head_ld & ~stall_i;
  assign ld_ready  = ~empty & head_ld & ~stall_i;
  assign retire    = (res_valid & res_ready) | (ld_valid & ld_ready);

  // A result offered while stalled is simply held, so only unstalled mismatches count.
  assign err_set = ~stall_i & ((res_valid & (empty | head_ld)) | (ld_valid & (empty | ~head_ld)));

  assign count = count_q;

  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] && (op_q[i] != OPECODE_CMP)) begin
        busy[rd_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        op_q[i] <= '0;
        rd_q[i] <= '0;
      end
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (retire) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (push) begin
        op_q[tail_q]  <= opecode;
        rd_q[tail_q]  <= rd_regno;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      unique case ({push, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en    <= 1'b0;
      wb_regno <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_en <= retire & ~head_cmp;
      if (retire) begin
        wb_regno <= rd_q[head_q];
        wb_data  <= head_ld ? ld_data : res_data;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Parametrised in-order writeback tracker that sits between decode/issue and the register file.
- Holds opecode and rd_regno for up to DEPTH in-flight instructions while the execute unit and the load path produce their results.
- Pairs each held entry with its result in issue order and produces a registered register-file write.
- Exports a per-register busy mask for hazard detection.
- Supports more than one outstanding instruction, non-writing ops (CMP) and producer-side ready handshakes.

## Interface
Parameters:
- LEN_OPECODE, 4, opecode width
- LEN_REGNO, 4, register-number width; NUM_REGS = 2**LEN_REGNO
- LEN_REG, 16, data width
- DEPTH, 4, queue entries (power of two, ≥2)
- OPECODE_LD, 4'h8, load opecode: its result comes from the ld_* port
- OPECODE_CMP, 4'h0, compare opecode: no register write

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- valid_i  in  1  issue request
- stall_o  out  1  issue refused this cycle
- opecode  in  LEN_OPECODE  issued opecode
- rd_regno  in  LEN_REGNO  issued destination register
- res_valid  in  1  execute result available
- res_data  in  LEN_REG  execute result
- res_ready  out  1  execute result consumed this cycle
- ld_valid  in  1  load data available
- ld_data  in  LEN_REG  load data
- ld_ready  out  1  load data consumed this cycle
- stall_i  in  1  downstream stall; blocks retirement
- wb_en  out  1  register-file write strobe
- wb_regno  out  LEN_REGNO  write register
- wb_data  out  LEN_REG  write data
- busy  out  NUM_REGS  bit r set while any held entry will write r
- count  out  log2(DEPTH)+1  held entries
- err  out  1  sticky protocol error

## Operation
Storage:
- Circular FIFO of {opecode, rd_regno, valid}, with head pointer, tail pointer and count.

Push:
- Condition: valid_i & ~full.
- stall_o = valid_i & full.
- A full queue refuses the push even if the head retires in the same cycle.

Head kind:
- ld if head opecode == OPECODE_LD, otherwise alu.

Ready signals:
- res_ready = ~empty & head is alu & ~stall_i.
- ld_ready = ~empty & head is ld & ~stall_i.

Retire:
- Condition: (res_valid & res_ready) | (ld_valid & ld_ready).
- Pop the head.
- Next cycle: wb_regno = head rd_regno.
- Next cycle: wb_data = ld_data if the head is ld, else res_data.
- Next cycle: wb_en = 1 unless the head opecode == OPECODE_CMP.
- With no retire, wb_en = 0 next cycle; wb_regno and wb_data hold.

Simultaneous events:
- Push and retire in the same cycle: both take effect and count is unchanged.
- Push into an empty queue: the entry can retire no earlier than the next cycle, because the head is registered.

busy:
- Combinational OR over held entries with opecode != OPECODE_CMP.
- Does not include the entry currently on wb_*.

err:
- Set when res_valid arrives while the queue is empty or the head is ld.
- Set when ld_valid arrives while the queue is empty or the head is alu.
- The offending data is dropped.
- A valid held while stall_i is asserted is not an error.
- err clears only on reset.

Reset (rst low, asynchronous):
- Clears pointers, count, entry valids, wb_en and err.
- wb_regno and wb_data reset to 0; busy reads 0.
- Mid-operation reset discards all held entries; no write is issued for them.

## Timing
Latency:
- Issue to earliest retire: 1 cycle.
- Retire to wb_en: 1 cycle (registered outputs).

Throughput:
- One push and one retire per cycle.

Combinational paths:
- stall_o, res_ready, ld_ready, busy and count are combinational from state and inputs.
- stall_o and res_ready/ld_ready depend on valid_i and stall_i respectively, with no other input-to-output paths.

stall_i:
- Freezes retirement only; pushes continue until full.

Pointer wrap:
- Pointers are modulo DEPTH.
- count distinguishes full (DEPTH) from empty (0).

## Test plan
- **Single ALU op.** Reset, then issue ADD r3, then res_valid=1, res_data=16'h1234 the next cycle. Required: res_ready=1; one cycle later wb_en=1, wb_regno=3, wb_data=16'h1234; busy[3] 1→0 on retire.
- **Fill and overflow.** Issue 4 ops to r1..r4 with no results (DEPTH=4). Required: count=4, busy=16'h001E. A 5th valid_i gives stall_o=1, count stays 4.
- **Mixed order.** Issue LD r5 then ADD r6; assert res_valid with 16'hAAAA first. Required: res_ready=0, err=1, no write. Then ld_valid with 16'h5555: wb r5=16'h5555. Then res_valid with 16'hBBBB: wb r6=16'hBBBB.
- **CMP and stall.** Issue CMP then ADD r2; hold stall_i=1 with res_valid=1 for 3 cycles. Required: no retire and err=0 throughout. Release: CMP retires with wb_en=0; the next cycle ADD retires and wb_en=1 one cycle later.
- **Wrap and mid-operation reset.** Perform 10 push/retire pairs in consecutive cycles to wrap the pointers. Required: data is returned in order and count stays 1. Assert rst low with 3 entries held. Required: count=0, busy=0, wb_en=0, err=0 immediately; no stale writes after release.
